nand_universal_shift_reg: RTL and testbench

Parametrised universal shift register whose per-bit mode multiplexer is built from 2-input NAND primitives. It is the sequential successor to the gate-from-NAND lab blocks. It supports hold, shift right, shift left and parallel load, and adds a saturating shift counter with a `done` flag so it can act as a WIDTH-bit serialiser/deserialiser. It sits between lab-level combinational gate exercises and later serial-link blocks.

---
 rtl/nand_usr_pkg.sv | 10 +
 rtl/nand_mux4.sv | 22 ++
 rtl/nand_universal_shift_reg.sv | 54 +++++
 tb/tb_nand_universal_shift_reg.sv | 126 ++++++++++++
 4 files changed

// File: rtl/nand_usr_pkg.sv
// nand_usr_pkg: mode encodings and counter sizing for the NAND-mux universal shift register
package nand_usr_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/nand_mux4.sv
// nand_mux4: 4:1 mux built only from 2-input NANDs (sel 00->d0, 01->d1, 10->d2, 11->d3)
module nand_mux4 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       y
);
  logic s0n, s1n, n0, n1, n2, n3, n4, n5, lo, hi;
  nand g_s0n (s0n, sel[0], sel[0]);
  nand g_s1n (s1n, sel[1], sel[1]);
  nand g_n0  (n0, d0, s0n);
  nand g_n1  (n1, d1, sel[0]);
  nand g_lo  (lo, n0, n1);
  nand g_n2  (n2, d2, s0n);
  nand g_n3  (n3, d3, sel[0]);
  nand g_hi  (hi, n2, n3);
  nand g_n4  (n4, lo, s1n);
  nand g_n5  (n5, hi, sel[1]);
  nand g_y   (y, n4, n5);
endmodule

// File: rtl/nand_universal_shift_reg.sv
// nand_universal_shift_reg: universal shift register with saturating shift count; define USR_ROTATE_EN to rotate instead of using sin_r/sin_l
module nand_universal_shift_reg
  import nand_usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic                          sin_r,
  input  logic                          sin_l,
  input  logic [WIDTH-1:0]              d,
  output logic [WIDTH-1:0]              q,
  output logic                          sout_r,
  output logic                          sout_l,
  output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
  output logic                          done
);
  localparam int CW = cnt_width(WIDTH);
  logic             in_r, in_l;
  logic [WIDTH-1:0] shr_src, shl_src, nxt;
`ifdef USR_ROTATE_EN
  assign in_r = q[0];
  assign in_l = q[WIDTH-1];
`else
  assign in_r = sin_r;
  assign in_l = sin_l;
`endif
  assign shr_src = {in_r, q[WIDTH-1:1]};
  assign shl_src = {q[WIDTH-2:0], in_l};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand_mux4 u_mux (
      .d0 (q[i]),
      .d1 (shr_src[i]),
      .d2 (shl_src[i]),
      .d3 (d[i]),
      .sel(mode),
      .y  (nxt[i])
    );
  end
  assign done   = shift_cnt == CW'(WIDTH);
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q         <= '0;
      shift_cnt <= '0;
    end else if (en) begin
      q         <= nxt;
      shift_cnt <= mode == MODE_LOAD ? '0 :
                   (mode == MODE_HOLD || done) ? shift_cnt : shift_cnt + 1'b1;
    end
endmodule

// File: tb/tb_nand_universal_shift_reg.sv
// tb_nand_universal_shift_reg: directed self-checking bench for the WIDTH=4 universal shift register
module tb_nand_universal_shift_reg;
  logic       clk = 0;
  logic       rst = 1;
  logic       en = 0;
  logic [1:0] mode = 2'b00;
  logic       sin_r = 0;
  logic       sin_l = 0;
  logic [3:0] d = '0;
  logic [3:0] q;
  logic       sout_r, sout_l, done;
  logic [2:0] shift_cnt;
  int         total = 0;
  int         bad = 0;
  nand_universal_shift_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l), .shift_cnt(shift_cnt), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] exp_sout;
    logic [3:0] exp_q [4];
    logic [3:0] sl_seq;
    #3;
    chk("rst_q", q, 4'b0000);
    chk("rst_cnt", shift_cnt, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 0;
    en = 1; mode = 2'b11; d = 4'b1010;
    step();
    chk("load_q", q, 4'b1010);
    chk("load_cnt", shift_cnt, 0);
    chk("load_sout_r", sout_r, 0);
    chk("load_sout_l", sout_l, 1);
    mode = 2'b00;
    repeat (3) step();
    chk("hold_q", q, 4'b1010);
    chk("hold_cnt", shift_cnt, 0);
    en = 0; mode = 2'b01; sin_r = 1;
    step();
    chk("en0_q", q, 4'b1010);
    chk("en0_cnt", shift_cnt, 0);
    en = 1;
`ifdef USR_ROTATE_EN
    mode = 2'b11; d = 4'b1000;
    step();
    exp_q = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    mode = 2'b01; sin_r = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rot_q%0d", k), q, exp_q[k]);
      chk($sformatf("rot_cnt%0d", k), shift_cnt, k + 1);
    end
    chk("rot_done", done, 1);
`else
    mode = 2'b11; d = 4'b1101;
    step();
    exp_sout = 4'b1101;
    mode = 2'b01; sin_r = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ser_sout%0d", k), sout_r, exp_sout[k]);
      step();
      chk($sformatf("ser_cnt%0d", k), shift_cnt, k + 1);
    end
    chk("ser_q", q, 4'b0000);
    chk("ser_done", done, 1);
    step();
    chk("sat_cnt", shift_cnt, 4);
    chk("sat_done", done, 1);
`endif
    mode = 2'b11; d = 4'b0110;
    step();
    chk("satload_q", q, 4'b0110);
    chk("satload_cnt", shift_cnt, 0);
    chk("satload_done", done, 0);
    d = 4'b0000;
    step();
    mode = 2'b01; sin_r = 1;
    repeat (2) step();
    mode = 2'b10; sin_l = 0;
    step();
`ifndef USR_ROTATE_EN
    chk("dir_q", q, 4'b1000);
`endif
    chk("dir_cnt", shift_cnt, 3);
    chk("dir_done", done, 0);
    mode = 2'b11; d = 4'b1011;
    step();
    chk("pre_rst_q", q, 4'b1011);
    #2;
    rst = 1;
    #1;
    chk("async_rst_q", q, 4'b0000);
    chk("async_rst_cnt", shift_cnt, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_sout_l", sout_l, 0);
`ifndef USR_ROTATE_EN
    sl_seq = 4'b1011;
    exp_q = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
    mode = 2'b10; sin_l = sl_seq[0];
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      sin_l = sl_seq[k];
      step();
      chk($sformatf("des_q%0d", k), q, exp_q[k]);
      chk($sformatf("des_done%0d", k), done, k == 3);
    end
`else
    rst = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
